// File: rtl/crtc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crtc_pkg
// Description : Shared constants and types for the CRTC timing sequencer:
//               register index map, address field widths, vertical state
//               and cursor blink mode encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package crtc_pkg;

    // CRTC register file indices ($E880 selects, $E881 writes)
    localparam int unsigned R0  = 0;
    localparam int unsigned R1  = 1;
    localparam int unsigned R2  = 2;
    localparam int unsigned R3  = 3;
    localparam int unsigned R4  = 4;
    localparam int unsigned R5  = 5;
    localparam int unsigned R6  = 6;
    localparam int unsigned R7  = 7;
    localparam int unsigned R8  = 8;
    localparam int unsigned R9  = 9;
    localparam int unsigned R10 = 10;
    localparam int unsigned R11 = 11;
    localparam int unsigned R12 = 12;
    localparam int unsigned R13 = 13;
    localparam int unsigned R14 = 14;
    localparam int unsigned R15 = 15;
    localparam int unsigned R16 = 16;
    localparam int unsigned R17 = 17;

    localparam int MA_W = 14;
    localparam int RA_W = 5;

    typedef enum logic [1:0] {
        V_ACTIVE = 2'd0,
        V_BORDER = 2'd1,
        V_ADJUST = 2'd2
    } v_state_t;

    typedef enum logic [1:0] {
        CUR_STEADY  = 2'd0,
        CUR_OFF     = 2'd1,
        CUR_BLINK16 = 2'd2,
        CUR_BLINK32 = 2'd3
    } cursor_mode_t;

endpackage
`default_nettype wire

// File: rtl/crtc_if.sv
`default_nettype none
// ============================================================================
// Module      : crtc_if
// Description : Register-value inputs and video timing outputs of the CRTC.
//               master = register file / video path side, slave = crtc_timing.
//               Cursor signals exist only when CRTC_CURSOR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface crtc_if;
    import crtc_pkg::*;

    logic            char_clk_en;
    logic [7:0]      r0_h_total;
    logic [7:0]      r1_h_displayed;
    logic [7:0]      r2_h_sync_pos;
    logic [7:0]      r3_sync_width;
    logic [6:0]      r4_v_total;
    logic [4:0]      r5_v_adjust;
    logic [6:0]      r6_v_displayed;
    logic [6:0]      r7_v_sync_pos;
    logic [4:0]      r9_max_scan_line;
    logic [5:0]      r12_start_hi;
    logic [7:0]      r13_start_lo;
    logic [MA_W-1:0] ma;
    logic [RA_W-1:0] ra;
    logic            de;
    logic            h_sync;
    logic            v_sync;
    logic            frame_start;

`ifdef CRTC_CURSOR_EN
    logic [6:0]      r10_cursor_start;
    logic [4:0]      r11_cursor_end;
    logic [5:0]      r14_cursor_hi;
    logic [7:0]      r15_cursor_lo;
    logic            cursor;

    modport master (
        output char_clk_en, r0_h_total, r1_h_displayed, r2_h_sync_pos,
               r3_sync_width, r4_v_total, r5_v_adjust, r6_v_displayed,
               r7_v_sync_pos, r9_max_scan_line, r12_start_hi, r13_start_lo,
               r10_cursor_start, r11_cursor_end, r14_cursor_hi, r15_cursor_lo,
        input  ma, ra, de, h_sync, v_sync, frame_start, cursor
    );
    modport slave (
        input  char_clk_en, r0_h_total, r1_h_displayed, r2_h_sync_pos,
               r3_sync_width, r4_v_total, r5_v_adjust, r6_v_displayed,
               r7_v_sync_pos, r9_max_scan_line, r12_start_hi, r13_start_lo,
               r10_cursor_start, r11_cursor_end, r14_cursor_hi, r15_cursor_lo,
        output ma, ra, de, h_sync, v_sync, frame_start, cursor
    );
`else
    modport master (
        output char_clk_en, r0_h_total, r1_h_displayed, r2_h_sync_pos,
               r3_sync_width, r4_v_total, r5_v_adjust, r6_v_displayed,
               r7_v_sync_pos, r9_max_scan_line, r12_start_hi, r13_start_lo,
        input  ma, ra, de, h_sync, v_sync, frame_start
    );
    modport slave (
        input  char_clk_en, r0_h_total, r1_h_displayed, r2_h_sync_pos,
               r3_sync_width, r4_v_total, r5_v_adjust, r6_v_displayed,
               r7_v_sync_pos, r9_max_scan_line, r12_start_hi, r13_start_lo,
        output ma, ra, de, h_sync, v_sync, frame_start
    );
`endif

endinterface
`default_nettype wire

// File: rtl/crtc_pulse_counter.sv
`default_nettype none
// ============================================================================
// Module      : crtc_pulse_counter
// Description : Sync pulse stretcher. i_start (qualified by i_tick) opens a
//               pulse lasting i_width ticks, width 0 meaning 16.
// Ports       : clk, rst (async, active-high), i_tick (advance), i_start,
//               i_width[3:0], o_active (registered pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module crtc_pulse_counter (
    input  wire        clk,
    input  wire        rst,
    input  wire        i_tick,
    input  wire        i_start,
    input  wire  [3:0] i_width,
    output logic       o_active
);

    logic [3:0] r_cnt;     // ticks remaining after the current one
    logic       r_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= 4'd0;
            r_active <= 1'b0;
        end else if (i_tick) begin
            if (i_start) begin
                // 0 - 1 wraps to 15, giving the 16-tick pulse for width 0
                r_cnt    <= i_width - 4'd1;
                r_active <= 1'b1;
            end else if (r_active) begin
                if (r_cnt == 4'd0) begin
                    r_active <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

    assign o_active = r_active;

endmodule
`default_nettype wire

// File: rtl/crtc_timing.sv
`default_nettype none
// ============================================================================
// Module      : crtc_timing
// Description : Character-rate CRTC sequencer. Walks horizontal, scan-line
//               and row counters on char_clk_en and produces MA, RA, DE,
//               HSYNC, VSYNC and a frame-start strobe, all registered and
//               describing the character just entered.
// Ports       : clk, reset (async, active-high), bus (crtc_if.slave)
// Options     : CRTC_CURSOR_EN adds R10/R11/R14/R15 inputs and cursor output
// Revision    : 1.0 - initial release
// ============================================================================
module crtc_timing
    import crtc_pkg::*;
(
    input  wire    clk,
    input  wire    reset,
    crtc_if.slave  bus
);

    logic [7:0]      r_h;
    logic [RA_W-1:0] r_ra;
    logic [6:0]      r_row;
    v_state_t        r_vstate;
    logic            r_pending;     // next enable begins a frame
    logic [MA_W-1:0] r_row_base;
    logic [MA_W-1:0] r_ma;
    logic            r_de;
    logic            r_frame_start;

    logic [7:0]      w_h_nxt;
    logic [RA_W-1:0] w_ra_nxt;
    logic [6:0]      w_row_nxt;
    v_state_t        w_vstate_nxt;
    logic [MA_W-1:0] w_row_base_nxt;
    logic [MA_W-1:0] w_ma_nxt;
    logic [MA_W-1:0] w_start_addr;
    logic            w_frame_new;
    logic            w_line_end;
    logic            w_line_tick;
    logic            w_de_nxt;
    logic            w_hs_start;
    logic            w_vs_start;

    // Next-position logic; >= comparisons keep counters bounded if the CPU
    // shrinks a limit register while the counter is already past it.
    always_comb begin
        w_frame_new    = r_pending;
        w_line_end     = 1'b0;
        w_h_nxt        = r_h + 8'd1;
        w_ra_nxt       = r_ra;
        w_row_nxt      = r_row;
        w_vstate_nxt   = r_vstate;
        w_row_base_nxt = r_row_base;
        w_ma_nxt       = r_ma + 14'd1;
        w_start_addr   = {bus.r12_start_hi, bus.r13_start_lo};

        if (!r_pending && (r_h >= bus.r0_h_total)) begin
            w_line_end = 1'b1;
            w_h_nxt    = 8'd0;
            if (r_vstate == V_ADJUST) begin
                // ra doubles as the adjust-line counter
                if (({1'b0, r_ra} + 6'd1) >= {1'b0, bus.r5_v_adjust}) begin
                    w_frame_new = 1'b1;
                end else begin
                    w_ra_nxt = r_ra + 5'd1;
                    w_ma_nxt = r_row_base;
                end
            end else if (r_ra >= bus.r9_max_scan_line) begin
                w_ra_nxt       = 5'd0;
                w_row_base_nxt = r_row_base + {6'd0, bus.r1_h_displayed};
                w_ma_nxt       = w_row_base_nxt;
                if (r_row >= bus.r4_v_total) begin
                    if (bus.r5_v_adjust == 5'd0) begin
                        w_frame_new = 1'b1;
                    end else begin
                        w_vstate_nxt = V_ADJUST;
                    end
                end else begin
                    w_row_nxt    = r_row + 7'd1;
                    w_vstate_nxt = (w_row_nxt < bus.r6_v_displayed) ? V_ACTIVE : V_BORDER;
                end
            end else begin
                w_ra_nxt = r_ra + 5'd1;
                w_ma_nxt = r_row_base;
            end
        end

        if (w_frame_new) begin
            w_h_nxt        = 8'd0;
            w_ra_nxt       = 5'd0;
            w_row_nxt      = 7'd0;
            w_vstate_nxt   = (bus.r6_v_displayed != 7'd0) ? V_ACTIVE : V_BORDER;
            w_row_base_nxt = w_start_addr;
            w_ma_nxt       = w_start_addr;
        end

        w_line_tick = w_line_end | w_frame_new;
        w_de_nxt    = (w_vstate_nxt == V_ACTIVE) && (w_h_nxt < bus.r1_h_displayed);
        w_hs_start  = (w_h_nxt == bus.r2_h_sync_pos);
        w_vs_start  = w_line_tick && (w_vstate_nxt != V_ADJUST) &&
                      (w_row_nxt == bus.r7_v_sync_pos) && (w_ra_nxt == 5'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h           <= 8'd0;
            r_ra          <= 5'd0;
            r_row         <= 7'd0;
            r_vstate      <= V_ACTIVE;
            r_pending     <= 1'b1;
            r_row_base    <= 14'd0;
            r_ma          <= 14'd0;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            // strobe lasts one clk even when enables are sparse
            r_frame_start <= bus.char_clk_en & w_frame_new;
            if (bus.char_clk_en) begin
                r_h        <= w_h_nxt;
                r_ra       <= w_ra_nxt;
                r_row      <= w_row_nxt;
                r_vstate   <= w_vstate_nxt;
                r_pending  <= 1'b0;
                r_row_base <= w_row_base_nxt;
                r_ma       <= w_ma_nxt;
                r_de       <= w_de_nxt;
            end
        end
    end

    crtc_pulse_counter u_hsync (
        .clk      (clk),
        .rst      (reset),
        .i_tick   (bus.char_clk_en),
        .i_start  (w_hs_start),
        .i_width  (bus.r3_sync_width[3:0]),
        .o_active (bus.h_sync)
    );

    crtc_pulse_counter u_vsync (
        .clk      (clk),
        .rst      (reset),
        .i_tick   (bus.char_clk_en & w_line_tick),
        .i_start  (w_vs_start),
        .i_width  (bus.r3_sync_width[7:4]),
        .o_active (bus.v_sync)
    );

    assign bus.ma          = r_ma;
    assign bus.ra          = r_ra;
    assign bus.de          = r_de;
    assign bus.frame_start = r_frame_start;

`ifdef CRTC_CURSOR_EN
    logic [4:0]   r_frame_cnt;
    logic         r_blink32;
    logic         r_cursor;
    logic         w_blink;
    logic         w_cursor_nxt;
    cursor_mode_t w_mode;

    always_comb begin
        w_mode  = cursor_mode_t'(bus.r10_cursor_start[6:5]);
        w_blink = 1'b1;
        case (w_mode)
            CUR_STEADY:  w_blink = 1'b1;
            CUR_OFF:     w_blink = 1'b0;
            CUR_BLINK16: w_blink = r_frame_cnt[4];
            default:     w_blink = r_blink32;
        endcase
        w_cursor_nxt = w_de_nxt && (w_ma_nxt == {bus.r14_cursor_hi, bus.r15_cursor_lo}) &&
                       (w_ra_nxt >= bus.r10_cursor_start[4:0]) &&
                       (w_ra_nxt <= bus.r11_cursor_end) && w_blink;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= 5'd0;
            r_blink32   <= 1'b0;
            r_cursor    <= 1'b0;
        end else if (bus.char_clk_en) begin
            r_cursor <= w_cursor_nxt;
            if (w_frame_new) begin
                r_frame_cnt <= r_frame_cnt + 5'd1;
                // counter wrap marks each 32-frame interval
                if (r_frame_cnt == 5'd31) begin
                    r_blink32 <= ~r_blink32;
                end
            end
        end
    end

    assign bus.cursor = r_cursor;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crtc_timing.sv
`default_nettype none
// ============================================================================
// Module      : tb_crtc_timing
// Description : Directed self-checking bench for crtc_timing. Common setup:
//               R0=9 R1=4 R2=6 R3=$22 R4=3 R5=1 R6=2 R7=2 R9=1 start=$0100,
//               giving 90 enables per frame (9 lines of 10 chars).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crtc_timing;
    import crtc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    crtc_if bus_if ();

    crtc_timing dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs at enable k of a frame starting at base.
    // Line = k/10 (lines 0..7 = rows 0..3 x 2 scan lines, line 8 = adjust).
    function automatic void expect_at(input int k, input logic [13:0] base,
                                      output logic [13:0] e_ma, output logic [4:0] e_ra,
                                      output logic e_de, output logic e_hs,
                                      output logic e_vs, output logic e_fs);
        int p;
        int line;
        int h;
        p    = k % 90;
        line = p / 10;
        h    = p % 10;
        e_fs = (p == 0);
        e_de = (line < 4) && (h < 4);
        e_hs = (h == 6) || (h == 7);
        e_vs = (line == 4) || (line == 5);
        e_ra = (line < 8) ? 5'(line % 2) : 5'd0;
        e_ma = 14'(base + 14'(4 * (line / 2)) + 14'(h));
    endfunction

    task automatic set_regs();
        bus_if.char_clk_en      = 1'b0;
        bus_if.r0_h_total       = 8'd9;
        bus_if.r1_h_displayed   = 8'd4;
        bus_if.r2_h_sync_pos    = 8'd6;
        bus_if.r3_sync_width    = 8'h22;
        bus_if.r4_v_total       = 7'd3;
        bus_if.r5_v_adjust      = 5'd1;
        bus_if.r6_v_displayed   = 7'd2;
        bus_if.r7_v_sync_pos    = 7'd2;
        bus_if.r9_max_scan_line = 5'd1;
        bus_if.r12_start_hi     = 6'h01;
        bus_if.r13_start_lo     = 8'h00;
`ifdef CRTC_CURSOR_EN
        bus_if.r10_cursor_start = 7'h00;
        bus_if.r11_cursor_end   = 5'd1;
        bus_if.r14_cursor_hi    = 6'h01;
        bus_if.r15_cursor_lo    = 8'h05;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_regs();
        repeat (3) tick();
        checks += 6;
        if (bus_if.ma !== 14'd0)      begin errors++; $display("FAIL reset_ma got %h exp 0", bus_if.ma); end
        if (bus_if.ra !== 5'd0)       begin errors++; $display("FAIL reset_ra got %h exp 0", bus_if.ra); end
        if (bus_if.de !== 1'b0)       begin errors++; $display("FAIL reset_de got %b exp 0", bus_if.de); end
        if (bus_if.h_sync !== 1'b0)   begin errors++; $display("FAIL reset_hs got %b exp 0", bus_if.h_sync); end
        if (bus_if.v_sync !== 1'b0)   begin errors++; $display("FAIL reset_vs got %b exp 0", bus_if.v_sync); end
        if (bus_if.frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b exp 0", bus_if.frame_start); end
    endtask

    // Two full frames from reset release, every output every enable
    task automatic test_frame();
        logic [13:0] e_ma;
        logic [4:0]  e_ra;
        logic        e_de, e_hs, e_vs, e_fs;
        reset = 1'b0;
        bus_if.char_clk_en = 1'b1;
        for (int k = 0; k < 180; k++) begin
            tick();
            expect_at(k, 14'h0100, e_ma, e_ra, e_de, e_hs, e_vs, e_fs);
            checks += 6;
            if (bus_if.ma !== e_ma) begin errors++; $display("FAIL frame_ma k=%0d got %h exp %h", k, bus_if.ma, e_ma); end
            if (bus_if.ra !== e_ra) begin errors++; $display("FAIL frame_ra k=%0d got %h exp %h", k, bus_if.ra, e_ra); end
            if (bus_if.de !== e_de) begin errors++; $display("FAIL frame_de k=%0d got %b exp %b", k, bus_if.de, e_de); end
            if (bus_if.h_sync !== e_hs) begin errors++; $display("FAIL frame_hs k=%0d got %b exp %b", k, bus_if.h_sync, e_hs); end
            if (bus_if.v_sync !== e_vs) begin errors++; $display("FAIL frame_vs k=%0d got %b exp %b", k, bus_if.v_sync, e_vs); end
            if (bus_if.frame_start !== e_fs) begin errors++; $display("FAIL frame_fs k=%0d got %b exp %b", k, bus_if.frame_start, e_fs); end
        end
    endtask

    // R13 written mid-frame only takes effect at the next frame start
    task automatic test_start_change();
        logic [13:0] e_ma;
        logic [4:0]  e_ra;
        logic        e_de, e_hs, e_vs, e_fs;
        for (int k = 0; k < 180; k++) begin
            tick();
            if (k == 45) bus_if.r13_start_lo = 8'h20;
            expect_at(k, (k < 90) ? 14'h0100 : 14'h0120, e_ma, e_ra, e_de, e_hs, e_vs, e_fs);
            checks += 2;
            if (bus_if.ma !== e_ma) begin errors++; $display("FAIL startchg_ma k=%0d got %h exp %h", k, bus_if.ma, e_ma); end
            if (bus_if.frame_start !== e_fs) begin errors++; $display("FAIL startchg_fs k=%0d got %b exp %b", k, bus_if.frame_start, e_fs); end
        end
    endtask

    // Start address $3FFE: MA and row base wrap modulo 2^14
    task automatic test_ma_wrap();
        logic [13:0] e_ma;
        logic [4:0]  e_ra;
        logic        e_de, e_hs, e_vs, e_fs;
        for (int k = 0; k < 180; k++) begin
            tick();
            if (k == 45) begin
                bus_if.r12_start_hi = 6'h3F;
                bus_if.r13_start_lo = 8'hFE;
            end
            if (k == 135) begin
                bus_if.r12_start_hi = 6'h01;
                bus_if.r13_start_lo = 8'h00;
            end
            expect_at(k, (k < 90) ? 14'h0120 : 14'h3FFE, e_ma, e_ra, e_de, e_hs, e_vs, e_fs);
            checks += 2;
            if (bus_if.ma !== e_ma) begin errors++; $display("FAIL wrap_ma k=%0d got %h exp %h", k, bus_if.ma, e_ma); end
            if (bus_if.de !== e_de) begin errors++; $display("FAIL wrap_de k=%0d got %b exp %b", k, bus_if.de, e_de); end
        end
    endtask

    // Reset mid-line (during hsync) clears everything; frame restarts
    task automatic test_reset_midline();
        logic [13:0] e_ma;
        logic [4:0]  e_ra;
        logic        e_de, e_hs, e_vs, e_fs;
        repeat (47) tick();   // line 4, h=6: hsync and vsync both high
        checks += 2;
        if (bus_if.h_sync !== 1'b1) begin errors++; $display("FAIL midline_pre_hs got %b exp 1", bus_if.h_sync); end
        if (bus_if.v_sync !== 1'b1) begin errors++; $display("FAIL midline_pre_vs got %b exp 1", bus_if.v_sync); end
        reset = 1'b1;
        #1;
        checks += 5;
        if (bus_if.ma !== 14'd0)    begin errors++; $display("FAIL midline_ma got %h exp 0", bus_if.ma); end
        if (bus_if.ra !== 5'd0)     begin errors++; $display("FAIL midline_ra got %h exp 0", bus_if.ra); end
        if (bus_if.de !== 1'b0)     begin errors++; $display("FAIL midline_de got %b exp 0", bus_if.de); end
        if (bus_if.h_sync !== 1'b0) begin errors++; $display("FAIL midline_hs got %b exp 0", bus_if.h_sync); end
        if (bus_if.v_sync !== 1'b0) begin errors++; $display("FAIL midline_vs got %b exp 0", bus_if.v_sync); end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 90; k++) begin
            tick();
            expect_at(k, 14'h0100, e_ma, e_ra, e_de, e_hs, e_vs, e_fs);
            checks += 4;
            if (bus_if.ma !== e_ma) begin errors++; $display("FAIL restart_ma k=%0d got %h exp %h", k, bus_if.ma, e_ma); end
            if (bus_if.frame_start !== e_fs) begin errors++; $display("FAIL restart_fs k=%0d got %b exp %b", k, bus_if.frame_start, e_fs); end
            if (bus_if.h_sync !== e_hs) begin errors++; $display("FAIL restart_hs k=%0d got %b exp %b", k, bus_if.h_sync, e_hs); end
            if (bus_if.v_sync !== e_vs) begin errors++; $display("FAIL restart_vs k=%0d got %b exp %b", k, bus_if.v_sync, e_vs); end
        end
    endtask

    // Sparse enables: outputs hold, frame_start lasts one clk
    task automatic test_gated_enable();
        bus_if.char_clk_en = 1'b0;
        tick();
        checks += 2;
        if (bus_if.ma !== 14'h0119) begin errors++; $display("FAIL gate_hold_ma got %h exp 0119", bus_if.ma); end
        if (bus_if.frame_start !== 1'b0) begin errors++; $display("FAIL gate_hold_fs got %b exp 0", bus_if.frame_start); end
        bus_if.char_clk_en = 1'b1;
        tick();
        bus_if.char_clk_en = 1'b0;
        checks += 2;
        if (bus_if.frame_start !== 1'b1) begin errors++; $display("FAIL gate_fs_on got %b exp 1", bus_if.frame_start); end
        if (bus_if.ma !== 14'h0100) begin errors++; $display("FAIL gate_ma0 got %h exp 0100", bus_if.ma); end
        tick();
        checks += 3;
        if (bus_if.frame_start !== 1'b0) begin errors++; $display("FAIL gate_fs_off got %b exp 0", bus_if.frame_start); end
        if (bus_if.ma !== 14'h0100) begin errors++; $display("FAIL gate_ma_hold got %h exp 0100", bus_if.ma); end
        if (bus_if.de !== 1'b1) begin errors++; $display("FAIL gate_de_hold got %b exp 1", bus_if.de); end
        tick();
        bus_if.char_clk_en = 1'b1;
        tick();
        checks += 2;
        if (bus_if.ma !== 14'h0101) begin errors++; $display("FAIL gate_ma1 got %h exp 0101", bus_if.ma); end
        if (bus_if.frame_start !== 1'b0) begin errors++; $display("FAIL gate_fs1 got %b exp 0", bus_if.frame_start); end
        repeat (88) tick();   // back to a frame boundary
    endtask

`ifdef CRTC_CURSOR_EN
    task automatic test_cursor();
        logic e_cur;
        int   line;
        int   h;
        for (int k = 0; k < 180; k++) begin
            tick();
            if (k == 89) bus_if.r10_cursor_start = 7'h20;
            line  = (k % 90) / 10;
            h     = k % 10;
            e_cur = (k < 90) && ((line == 2) || (line == 3)) && (h == 1);
            checks++;
            if (bus_if.cursor !== e_cur) begin errors++; $display("FAIL cursor k=%0d got %b exp %b", k, bus_if.cursor, e_cur); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_start_change();
        test_ma_wrap();
        test_reset_midline();
        test_gated_enable();
`ifdef CRTC_CURSOR_EN
        test_cursor();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
